projectile_pool: RTL and testbench

- Multi-slot ballistic projectile engine; successor to the single-bomb mover.
- Manages NUM_SLOTS independent projectiles, each with its own gravity, clamping, bounds check, collision response and an expanding-blast phase.
- Sits between the turret/launch logic and the terrain deformer and renderer.
- Single clock domain: frame motion is advanced by a one-cycle frame_tick strobe, not a separate frame clock.

---
 rtl/projectile_pool.sv | 264 ++++++++++++++++++++++++++
 tb/tb_projectile_pool.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/projectile_pool.sv
// Multi-slot ballistic projectile engine: per-slot IDLE->FLY->BOOM->IDLE with gravity, clamping, bounds and blast growth.
// Optional wind input enabled by defining PROJECTILE_POOL_WIND_EN.
module projectile_pool #(
    parameter int NUM_SLOTS   = 4,
    parameter int COORD_W     = 10,
    parameter int V_MAX       = 12,
    parameter int GRAV_DIV    = 6,
    parameter int BOOM_RADIUS = 16,
    parameter int X_MIN       = 5,
    parameter int X_MAX       = 634,
    parameter int Y_MIN       = 5,
    parameter int Y_MAX       = 474,
    parameter int SPR_W       = 12,
    parameter int SPR_H       = 17,
    parameter int SPR_CX      = 5,
    parameter int SPR_CY      = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_tick,
    input  logic                           launch,
    input  logic [COORD_W-1:0]             launch_x,
    input  logic [COORD_W-1:0]             launch_y,
    input  logic [COORD_W-1:0]             launch_vx,
    input  logic [COORD_W-1:0]             launch_vy,
`ifdef PROJECTILE_POOL_WIND_EN
    input  logic signed [3:0]              wind,
`endif
    output logic                           launch_ready,
    output logic [2:0]                     launch_slot,
    input  logic [NUM_SLOTS-1:0]           hit_vec,
    output logic [NUM_SLOTS*COORD_W-1:0]   pos_x_flat,
    output logic [NUM_SLOTS*COORD_W-1:0]   pos_y_flat,
    output logic [NUM_SLOTS-1:0]           flying,
    output logic [NUM_SLOTS-1:0]           booming,
    output logic [NUM_SLOTS*COORD_W-1:0]   boom_r_flat,
    input  logic [COORD_W-1:0]             draw_x,
    input  logic [COORD_W-1:0]             draw_y,
    output logic                           draw_bomb,
    output logic [2:0]                     draw_slot,
    output logic [17:0]                    draw_addr
);

    // Two guard bits so position+velocity and pixel offsets never wrap before comparison.
    localparam int XW = COORD_W + 2;
    localparam int GW = $clog2(GRAV_DIV + 1);

    localparam logic signed [XW-1:0] L_VMAX  = XW'(V_MAX);
    localparam logic signed [XW-1:0] L_VMIN  = -XW'(V_MAX);
    localparam logic signed [XW-1:0] L_ONE   = XW'(1);
    localparam logic signed [XW-1:0] L_ZERO  = XW'(0);
    localparam logic signed [XW-1:0] L_XMIN  = XW'(X_MIN);
    localparam logic signed [XW-1:0] L_XMAX  = XW'(X_MAX);
    localparam logic signed [XW-1:0] L_YMIN  = XW'(Y_MIN);
    localparam logic signed [XW-1:0] L_YMAX  = XW'(Y_MAX);
    localparam logic signed [XW-1:0] L_SCX   = XW'(SPR_CX);
    localparam logic signed [XW-1:0] L_SCY   = XW'(SPR_CY);
    localparam logic signed [XW-1:0] L_SWM1  = XW'(SPR_W - 1);
    localparam logic signed [XW-1:0] L_SHM1  = XW'(SPR_H - 1);
    localparam logic [GW-1:0]        L_GLAST = GW'(GRAV_DIV - 1);
    localparam logic [COORD_W-1:0]   L_RMAX  = COORD_W'(BOOM_RADIUS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_BOOM = 2'd2
    } state_t;

    state_t                     r_state [NUM_SLOTS];
    logic [COORD_W-1:0]         r_x     [NUM_SLOTS];
    logic [COORD_W-1:0]         r_y     [NUM_SLOTS];
    logic signed [COORD_W-1:0]  r_vx    [NUM_SLOTS];
    logic signed [COORD_W-1:0]  r_vy    [NUM_SLOTS];
    logic [GW-1:0]              r_gcnt  [NUM_SLOTS];
    logic [COORD_W-1:0]         r_rad   [NUM_SLOTS];

    state_t                     w_state_n [NUM_SLOTS];
    logic [COORD_W-1:0]         w_x_n     [NUM_SLOTS];
    logic [COORD_W-1:0]         w_y_n     [NUM_SLOTS];
    logic signed [COORD_W-1:0]  w_vx_n    [NUM_SLOTS];
    logic signed [COORD_W-1:0]  w_vy_n    [NUM_SLOTS];
    logic [GW-1:0]              w_gcnt_n  [NUM_SLOTS];
    logic [COORD_W-1:0]         w_rad_n   [NUM_SLOTS];

    logic signed [XW-1:0]       w_nx      [NUM_SLOTS];
    logic signed [XW-1:0]       w_ny      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]       w_oob;
    logic signed [COORD_W-1:0]  w_vy_grav [NUM_SLOTS];
    logic signed [COORD_W-1:0]  w_vx_grav [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]       w_ld;
    logic signed [COORD_W-1:0]  w_lvx;
    logic signed [COORD_W-1:0]  w_lvy;

    logic signed [XW-1:0]       w_dx      [NUM_SLOTS];
    logic signed [XW-1:0]       w_dy      [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]       w_in_box;

    function automatic logic signed [XW-1:0] f_sext(input logic [COORD_W-1:0] v);
        return $signed({{2{v[COORD_W-1]}}, v});
    endfunction

    function automatic logic signed [COORD_W-1:0] f_clamp(input logic signed [XW-1:0] v);
        logic signed [XW-1:0] c;
        c = v;
        if (v > L_VMAX)
            c = L_VMAX;
        else if (v < L_VMIN)
            c = L_VMIN;
        return $signed(c[COORD_W-1:0]);
    endfunction

    // Launch arbitration: lowest-index IDLE slot wins.
    always_comb begin
        launch_ready = 1'b0;
        launch_slot  = 3'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_state[i] == S_IDLE) begin
                launch_ready = 1'b1;
                launch_slot  = 3'(i);
            end
        end
    end

    assign w_lvx = f_clamp(f_sext(launch_vx));
    assign w_lvy = f_clamp(f_sext(launch_vy));

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_ld[i]      = launch && launch_ready && (launch_slot == 3'(i));
            w_nx[i]      = $signed({2'b00, r_x[i]}) + f_sext(r_vx[i]);
            w_ny[i]      = $signed({2'b00, r_y[i]}) + f_sext(r_vy[i]);
            w_oob[i]     = (w_nx[i] < L_XMIN) || (w_nx[i] > L_XMAX) ||
                           (w_ny[i] < L_YMIN) || (w_ny[i] > L_YMAX);
            w_vy_grav[i] = f_clamp(f_sext(r_vy[i]) + L_ONE);
`ifdef PROJECTILE_POOL_WIND_EN
            w_vx_grav[i] = f_clamp(f_sext(r_vx[i]) + $signed({{(XW-4){wind[3]}}, wind}));
`else
            w_vx_grav[i] = r_vx[i];
`endif
        end
    end

    // Per-slot next-state logic.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_state_n[i] = r_state[i];
            w_x_n[i]     = r_x[i];
            w_y_n[i]     = r_y[i];
            w_vx_n[i]    = r_vx[i];
            w_vy_n[i]    = r_vy[i];
            w_gcnt_n[i]  = r_gcnt[i];
            w_rad_n[i]   = r_rad[i];
            case (r_state[i])
                S_IDLE: begin
                    if (w_ld[i]) begin
                        w_state_n[i] = S_FLY;
                        w_x_n[i]     = launch_x;
                        w_y_n[i]     = launch_y;
                        w_vx_n[i]    = w_lvx;
                        w_vy_n[i]    = w_lvy;
                        w_gcnt_n[i]  = '0;
                        w_rad_n[i]   = '0;
                    end
                end
                S_FLY: begin
                    if (frame_tick) begin
                        if (hit_vec[i] || w_oob[i]) begin
                            w_state_n[i] = S_BOOM;
                            w_rad_n[i]   = COORD_W'(1);
                        end else begin
                            w_x_n[i] = w_nx[i][COORD_W-1:0];
                            w_y_n[i] = w_ny[i][COORD_W-1:0];
                            if (r_gcnt[i] == L_GLAST) begin
                                w_gcnt_n[i] = '0;
                                w_vy_n[i]   = w_vy_grav[i];
                                w_vx_n[i]   = w_vx_grav[i];
                            end else begin
                                w_gcnt_n[i] = r_gcnt[i] + 1'b1;
                            end
                        end
                    end
                end
                S_BOOM: begin
                    if (frame_tick) begin
                        if (r_rad[i] == L_RMAX) begin
                            w_state_n[i] = S_IDLE;
                            w_rad_n[i]   = '0;
                        end else begin
                            w_rad_n[i]   = r_rad[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_n[i] = S_IDLE;
                    w_rad_n[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_vx[i]    <= '0;
                r_vy[i]    <= '0;
                r_gcnt[i]  <= '0;
                r_rad[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_state[i] <= w_state_n[i];
                r_x[i]     <= w_x_n[i];
                r_y[i]     <= w_y_n[i];
                r_vx[i]    <= w_vx_n[i];
                r_vy[i]    <= w_vy_n[i];
                r_gcnt[i]  <= w_gcnt_n[i];
                r_rad[i]   <= w_rad_n[i];
            end
        end
    end

    always_comb begin
        pos_x_flat  = '0;
        pos_y_flat  = '0;
        boom_r_flat = '0;
        flying      = '0;
        booming     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            pos_x_flat[i*COORD_W +: COORD_W]  = r_x[i];
            pos_y_flat[i*COORD_W +: COORD_W]  = r_y[i];
            flying[i]                         = (r_state[i] == S_FLY);
            booming[i]                        = (r_state[i] == S_BOOM);
            boom_r_flat[i*COORD_W +: COORD_W] = (r_state[i] == S_BOOM) ? r_rad[i] : '0;
        end
    end

    // Offsets are taken relative to the sprite's top-left corner, so the box test is 0..SPR_W-1.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_dx[i]     = $signed({2'b00, draw_x}) - $signed({2'b00, r_x[i]}) + L_SCX;
            w_dy[i]     = $signed({2'b00, draw_y}) - $signed({2'b00, r_y[i]}) + L_SCY;
            w_in_box[i] = (r_state[i] == S_FLY) &&
                          (w_dx[i] >= L_ZERO) && (w_dx[i] <= L_SWM1) &&
                          (w_dy[i] >= L_ZERO) && (w_dy[i] <= L_SHM1);
        end
    end

    always_comb begin
        draw_bomb = 1'b0;
        draw_slot = 3'd0;
        draw_addr = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_in_box[i]) begin
                draw_bomb = 1'b1;
                draw_slot = 3'(i);
                draw_addr = 18'(SPR_W) * 18'($unsigned(w_dy[i])) + 18'($unsigned(w_dx[i]));
            end
        end
    end

endmodule

// File: tb/tb_projectile_pool.sv
// Directed bench for projectile_pool: table-driven draw-path vectors plus hand sequences for flight, blast and reset.
module tb_projectile_pool;

    localparam int N  = 4;
    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_tick;
    logic            launch;
    logic [CW-1:0]   launch_x, launch_y, launch_vx, launch_vy;
    logic            launch_ready;
    logic [2:0]      launch_slot;
    logic [N-1:0]    hit_vec;
    logic [N*CW-1:0] pos_x_flat, pos_y_flat, boom_r_flat;
    logic [N-1:0]    flying, booming;
    logic [CW-1:0]   draw_x, draw_y;
    logic            draw_bomb;
    logic [2:0]      draw_slot;
    logic [17:0]     draw_addr;

    int n_tests = 0;
    int n_fail  = 0;

    projectile_pool dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .launch       (launch),
        .launch_x     (launch_x),
        .launch_y     (launch_y),
        .launch_vx    (launch_vx),
        .launch_vy    (launch_vy),
        .launch_ready (launch_ready),
        .launch_slot  (launch_slot),
        .hit_vec      (hit_vec),
        .pos_x_flat   (pos_x_flat),
        .pos_y_flat   (pos_y_flat),
        .flying       (flying),
        .booming      (booming),
        .boom_r_flat  (boom_r_flat),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_bomb    (draw_bomb),
        .draw_slot    (draw_slot),
        .draw_addr    (draw_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dx;
        int dy;
        int bomb;
        int slot;
        int addr;
    } draw_vec_t;

    draw_vec_t vecs [8];

    function automatic int px(input int i);
        return int'(pos_x_flat[i*CW +: CW]);
    endfunction
    function automatic int py(input int i);
        return int'(pos_y_flat[i*CW +: CW]);
    endfunction
    function automatic int rad(input int i);
        return int'(boom_r_flat[i*CW +: CW]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        launch     = 1'b0;
        launch_x   = '0;
        launch_y   = '0;
        launch_vx  = '0;
        launch_vy  = '0;
        hit_vec    = '0;
        draw_x     = '0;
        draw_y     = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_launch(input int x, input int y, input int vx, input int vy);
        launch    = 1'b1;
        launch_x  = CW'(x);
        launch_y  = CW'(y);
        launch_vx = CW'(vx);
        launch_vy = CW'(vy);
    endtask

    task automatic do_launch(input int x, input int y, input int vx, input int vy);
        set_launch(x, y, vx, vy);
        @(posedge clk);
        #1;
        launch = 1'b0;
    endtask

    task automatic tick(input logic [N-1:0] hits);
        hit_vec    = hits;
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        hit_vec    = '0;
    endtask

    initial begin
        vecs[0] = '{dx: 295, dy:  91, bomb: 1, slot: 0, addr:   0};
        vecs[1] = '{dx: 306, dy: 107, bomb: 1, slot: 0, addr: 203};
        vecs[2] = '{dx: 307, dy: 107, bomb: 1, slot: 2, addr: 201};
        vecs[3] = '{dx: 310, dy: 107, bomb: 0, slot: 0, addr:   0};
        vecs[4] = '{dx: 306, dy: 108, bomb: 0, slot: 0, addr:   0};
        vecs[5] = '{dx: 395, dy:  91, bomb: 1, slot: 1, addr:   0};
        vecs[6] = '{dx: 400, dy:  95, bomb: 1, slot: 1, addr:  53};
        vecs[7] = '{dx: 294, dy:  91, bomb: 0, slot: 0, addr:   0};

        // Reset values while reset is still held.
        reset = 1'b1; frame_tick = 1'b0; launch = 1'b0; hit_vec = '0;
        launch_x = '0; launch_y = '0; launch_vx = '0; launch_vy = '0;
        draw_x = '0; draw_y = '0;
        #2;
        check("rst_flying", int'(flying), 0);
        check("rst_booming", int'(booming), 0);
        check("rst_ready", int'(launch_ready), 1);
        check("rst_slot", int'(launch_slot), 0);
        check("rst_draw", int'(draw_bomb), 0);
        do_reset();

        // Basic flight with gravity.
        do_launch(100, 200, 3, -5);
        check("l0_flying", int'(flying), 1);
        check("l0_x", px(0), 100);
        check("l0_y", py(0), 200);
        check("l0_next_slot", int'(launch_slot), 1);
        tick('0);
        check("t1_x", px(0), 103);
        check("t1_y", py(0), 195);
        for (int k = 0; k < 5; k++) tick('0);
        check("t6_x", px(0), 118);
        check("t6_y", py(0), 170);
        tick('0);
        check("t7_x", px(0), 121);
        check("t7_y_vy_m4", py(0), 166);

        // Fill all slots, then drop a fifth launch.
        do_reset();
        for (int s = 0; s < 4; s++) do_launch(50 + 10*s, 100, 1, 0);
        check("full_flying", int'(flying), 15);
        check("full_ready", int'(launch_ready), 0);
        do_launch(500, 400, 2, 2);
        check("drop_flying", int'(flying), 15);
        check("drop_ready", int'(launch_ready), 0);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("drop_x%0d", s), px(s), 50 + 10*s);
            check($sformatf("drop_y%0d", s), py(s), 100);
        end

        // Right-edge exit and blast lifetime; hit_vec ignored during blast.
        do_reset();
        do_launch(632, 200, 3, 0);
        tick('0);
        check("edge_boom", int'(booming), 1);
        check("edge_fly", int'(flying), 0);
        check("edge_x", px(0), 632);
        check("edge_r1", rad(0), 1);
        for (int k = 0; k < 14; k++) tick(4'b1111);
        check("edge_r15", rad(0), 15);
        tick('0);
        check("edge_r16", rad(0), 16);
        check("edge_boom16", int'(booming), 1);
        tick('0);
        check("edge_idle_boom", int'(booming), 0);
        check("edge_idle_r", rad(0), 0);
        check("edge_idle_ready", int'(launch_ready), 1);

        // Collision on slot 1 only.
        do_reset();
        do_launch(100, 200, 3, -5);
        do_launch(200, 200, 1, -1);
        tick(4'b0010);
        check("hit_boom", int'(booming), 2);
        check("hit_fly", int'(flying), 1);
        check("hit_x1", px(1), 200);
        check("hit_y1", py(1), 200);
        check("hit_r1", rad(1), 1);
        check("hit_x0", px(0), 103);
        check("hit_y0", py(0), 195);

        // Velocity clamp and launch coincident with a tick.
        do_reset();
        do_launch(300, 300, 20, -20);
        tick('0);
        check("clamp_x", px(0), 312);
        check("clamp_y", py(0), 288);
        set_launch(50, 60, 1, 1);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        launch = 1'b0; frame_tick = 1'b0;
        check("coinc_x0", px(0), 324);
        check("coinc_y0", py(0), 276);
        check("coinc_x1", px(1), 50);
        check("coinc_y1", py(1), 60);
        check("coinc_fly", int'(flying), 3);
        tick('0);
        check("coinc_x1_t", px(1), 51);
        check("coinc_y1_t", py(1), 61);

        // Draw path from the vector table.
        do_reset();
        do_launch(300, 100, 0, 0);
        do_launch(400, 100, 0, 0);
        do_launch(303, 100, 0, 0);
        for (int v = 0; v < 8; v++) begin
            draw_x = CW'(vecs[v].dx);
            draw_y = CW'(vecs[v].dy);
            #1;
            check($sformatf("draw%0d_bomb", v), int'(draw_bomb), vecs[v].bomb);
            check($sformatf("draw%0d_slot", v), int'(draw_slot), vecs[v].slot);
            check($sformatf("draw%0d_addr", v), int'(draw_addr), vecs[v].addr);
        end

        // Asynchronous reset in the middle of a blast.
        do_reset();
        do_launch(632, 200, 3, 0);
        do_launch(300, 100, 0, 0);
        tick('0);
        tick('0);
        draw_x = CW'(295); draw_y = CW'(91);
        #1;
        check("pre_rst_boom", int'(booming), 1);
        check("pre_rst_draw", int'(draw_bomb), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_boom", int'(booming), 0);
        check("mid_rst_fly", int'(flying), 0);
        check("mid_rst_r", rad(0), 0);
        check("mid_rst_x0", px(0), 0);
        check("mid_rst_x1", px(1), 0);
        check("mid_rst_ready", int'(launch_ready), 1);
        check("mid_rst_slot", int'(launch_slot), 0);
        check("mid_rst_draw", int'(draw_bomb), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
